// File: rtl/lsu_pkg.sv
// Shared encodings and constants for the load/store memory master.
package lsu_pkg;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RMW_RD,
        ST_WR,
        ST_RESP
    } state_e;
endpackage

// File: rtl/lsu_mem_master_align.sv
// Lane extraction, sign/zero extension, sub-word store merge and alignment check.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] merged,
    output logic        misalign
);
    logic [31:0] lane;
    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;

    always_comb begin
        byte_sh  = {addr_lo, 3'b000};
        half_sh  = {addr_lo[1], 4'b0000};
        lane     = word >> byte_sh;
        load_val = word;
        merged   = word;
        case (size)
            SZ_B: begin
                load_val = is_unsigned ? {24'd0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
                merged[byte_sh +: 8] = wdata[7:0];
            end
            SZ_H: begin
                load_val = is_unsigned ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
                merged[half_sh +: 16] = wdata[15:0];
            end
            default: ;
        endcase
        misalign = (size == 2'd3) ||
                   (size == SZ_H && addr_lo[0]) ||
                   (size == SZ_W && addr_lo != 2'b00);
    end
endmodule

// File: rtl/lsu_mem_master.sv
// Single-outstanding load/store initiator driving a word-addressed RAM;
// sub-word stores are done as read-modify-write.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = lsu_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = lsu_pkg::DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_valid,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            size_q, size_d;
    logic                  wen_q, wen_d;
    logic                  uns_q, uns_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  idle;
    logic [1:0]            al_addr_lo;
    logic [1:0]            al_size;
    logic [31:0]           al_load;
    logic [31:0]           al_merged;
    logic                  al_misalign;

    // In IDLE the aligner checks the incoming request; otherwise it works on the latched one.
    assign idle       = (state_q == ST_IDLE);
    assign al_addr_lo = idle ? req_addr[1:0] : addr_q[1:0];
    assign al_size    = idle ? req_size : size_q;

    lsu_align u_align (
        .word        (mem_rdata),
        .addr_lo     (al_addr_lo),
        .size        (al_size),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .load_val    (al_load),
        .merged      (al_merged),
        .misalign    (al_misalign)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        wen_d   = wen_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    size_d  = req_size;
                    wen_d   = req_wen;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (al_misalign) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else if (!req_wen) begin
                        state_d = ST_RD;
                    end else if (req_size == SZ_W) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RMW_RD;
                    end
                end
            end
            ST_RD: begin
                rdata_d = al_load;
                state_d = ST_RESP;
            end
            ST_RMW_RD: begin
                wdata_d = al_merged;
                state_d = ST_WR;
            end
            ST_WR:   state_d = ST_RESP;
            ST_RESP: if (resp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are forced to zero while reset is held, so a reset during WR suppresses the write.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_err   = 1'b0;
        mem_valid  = 1'b0;
        mem_wen    = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (reset_n) begin
            case (state_q)
                ST_IDLE: req_ready = 1'b1;
                ST_RD, ST_RMW_RD: begin
                    mem_valid = 1'b1;
                    mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
                end
                ST_WR: begin
                    mem_valid = 1'b1;
                    mem_wen   = 1'b1;
                    mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
                    mem_wdata = wdata_q;
                end
                ST_RESP: begin
                    resp_valid = 1'b1;
                    resp_rdata = rdata_q;
                    resp_err   = err_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            wen_q   <= 1'b0;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            wen_q   <= wen_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a behavioural word RAM.
module tb_lsu_mem_master;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_wen, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_valid, mem_wen;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] ram [0:1023];
    int          wr_count = 0;
    int          nvec = 0;
    int          nfail = 0;

    always #5 clock = ~clock;

    lsu_mem_master dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_valid(mem_valid),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    assign mem_rdata = ram[mem_addr[11:2]];

    always @(posedge clock) begin
        if (mem_valid && mem_wen) begin
            ram[mem_addr[11:2]] <= mem_wdata;
            wr_count <= wr_count + 1;
        end
    end

    typedef struct {
        logic        wen;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_strb;
        int          exp_wr;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic wen, logic [1:0] size, logic uns, logic [31:0] addr,
                                logic [31:0] wdata, logic [31:0] exp_rdata, logic exp_err,
                                int exp_lat, int exp_strb, int exp_wr, logic [31:0] exp_wdata);
        vec_t v;
        v.wen = wen; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
        v.exp_strb = exp_strb; v.exp_wr = exp_wr; v.exp_wdata = exp_wdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat, strb, wr, addr_bad;
        logic [31:0] last_wd;
        lat = 0; strb = 0; wr = 0; addr_bad = 0; last_wd = '0;
        @(negedge clock);
        chk($sformatf("v%0d req_ready", idx), {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_wen = v.wen; req_size = v.size; req_unsigned = v.uns;
        req_addr = v.addr; req_wdata = v.wdata;
        @(posedge clock);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (k == 1) begin
                req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A;
            end
            if (mem_valid) begin
                strb++;
                if (mem_addr !== {v.addr[31:2], 2'b00}) addr_bad++;
                if (mem_wen) begin wr++; last_wd = mem_wdata; end
            end
            if (resp_valid) begin lat = k; break; end
        end
        chk($sformatf("v%0d latency", idx), lat, v.exp_lat);
        chk($sformatf("v%0d strobes", idx), strb, v.exp_strb);
        chk($sformatf("v%0d writes", idx), wr, v.exp_wr);
        chk($sformatf("v%0d mem_addr_bad", idx), addr_bad, 0);
        chk($sformatf("v%0d rdata", idx), resp_rdata, v.exp_rdata);
        chk($sformatf("v%0d err", idx), {31'd0, resp_err}, {31'd0, v.exp_err});
        if (v.exp_wr > 0) chk($sformatf("v%0d wdata", idx), last_wd, v.exp_wdata);
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
        chk($sformatf("v%0d idle_ready", idx), {31'd0, req_ready}, 32'd1);
        chk($sformatf("v%0d idle_resp_valid", idx), {31'd0, resp_valid}, 32'd0);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, " req_ready"},  {31'd0, req_ready}, 32'd0);
        chk({name, " resp_valid"}, {31'd0, resp_valid}, 32'd0);
        chk({name, " resp_rdata"}, resp_rdata, 32'd0);
        chk({name, " resp_err"},   {31'd0, resp_err}, 32'd0);
        chk({name, " mem_valid"},  {31'd0, mem_valid}, 32'd0);
        chk({name, " mem_wen"},    {31'd0, mem_wen}, 32'd0);
        chk({name, " mem_addr"},   mem_addr, 32'd0);
        chk({name, " mem_wdata"},  mem_wdata, 32'd0);
    endtask

    initial begin
        logic [31:0] held;
        int snap;
        for (int i = 0; i < 1024; i++) ram[i] = 32'd0;
        ram[32'h100 >> 2] = 32'h80FF_7F01;
        reset_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;

        // wen size uns addr wdata | rdata err lat strobes writes wdata
        vecs.push_back(mk(0, 0, 0, 32'h103, 0, 32'hFFFF_FF80, 0, 2, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 32'h103, 0, 32'h0000_0080, 0, 2, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h101, 0, 32'h0000_007F, 0, 2, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h102, 0, 32'hFFFF_80FF, 0, 2, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 32'h100, 0, 32'h0000_7F01, 0, 2, 1, 0, 0));
        vecs.push_back(mk(0, 2, 0, 32'h100, 0, 32'h80FF_7F01, 0, 2, 1, 0, 0));
        vecs.push_back(mk(1, 2, 0, 32'h100, 32'h1122_3344, 0, 0, 2, 1, 1, 32'h1122_3344));
        vecs.push_back(mk(1, 1, 0, 32'h102, 32'h1234_BEEF, 0, 0, 3, 2, 1, 32'hBEEF_3344));
        vecs.push_back(mk(1, 0, 0, 32'h101, 32'hFFFF_FFA5, 0, 0, 3, 2, 1, 32'hBEEF_A544));
        vecs.push_back(mk(0, 2, 0, 32'h100, 0, 32'hBEEF_A544, 0, 2, 1, 0, 0));
        vecs.push_back(mk(1, 2, 0, 32'h200, 32'hDEAD_BEEF, 0, 0, 2, 1, 1, 32'hDEAD_BEEF));
        vecs.push_back(mk(0, 2, 0, 32'h200, 0, 32'hDEAD_BEEF, 0, 2, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 32'h202, 0, 32'h0000_DEAD, 0, 2, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h200, 0, 32'hFFFF_FFEF, 0, 2, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h203, 0, 32'hFFFF_FFDE, 0, 2, 1, 0, 0));
        vecs.push_back(mk(0, 2, 0, 32'h102, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h101, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 3, 0, 32'h100, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 32'h103, 32'hFFFF_FFFF, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 2, 0, 32'h100, 0, 32'hBEEF_A544, 0, 2, 1, 0, 0));

        repeat (3) @(negedge clock);
        chk_all_zero("reset");
        reset_n = 1'b1;
        #1;
        chk("reset_release req_ready", {31'd0, req_ready}, 32'd1);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Response stall: data must hold, nothing new accepted, even with req_valid high.
        @(negedge clock);
        req_valid = 1'b1; req_wen = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h200;
        @(posedge clock);
        repeat (2) @(negedge clock);
        req_addr = 32'h100;
        held = resp_rdata;
        chk("stall first rdata", held, 32'hDEAD_BEEF);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall%0d resp_valid", k), {31'd0, resp_valid}, 32'd1);
            chk($sformatf("stall%0d rdata", k), resp_rdata, 32'hDEAD_BEEF);
            chk($sformatf("stall%0d req_ready", k), {31'd0, req_ready}, 32'd0);
            chk($sformatf("stall%0d mem_valid", k), {31'd0, mem_valid}, 32'd0);
            @(negedge clock);
        end
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
        chk("post_handshake req_ready", {31'd0, req_ready}, 32'd1);
        chk("post_handshake mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("post_handshake resp_valid", {31'd0, resp_valid}, 32'd0);
        req_valid = 1'b0;

        // Reset during the WR cycle of a byte store.
        @(negedge clock);
        snap = wr_count;
        req_valid = 1'b1; req_wen = 1'b1; req_size = 2'd0; req_addr = 32'h201; req_wdata = 32'h11;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        chk("rst_seq rmw_rd mem_valid", {31'd0, mem_valid}, 32'd1);
        chk("rst_seq rmw_rd mem_wen", {31'd0, mem_wen}, 32'd0);
        @(negedge clock);
        chk("rst_seq wr mem_wen", {31'd0, mem_wen}, 32'd1);
        chk("rst_seq wr mem_wdata", mem_wdata, 32'hDEAD_11EF);
        reset_n = 1'b0;
        #1;
        chk_all_zero("rst_in_wr");
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("rst_after req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_after resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_after write_count", wr_count, snap);
        chk("rst_after ram_word", ram[32'h200 >> 2], 32'hDEAD_BEEF);
        run_vec(mk(0, 2, 0, 32'h200, 0, 32'hDEAD_BEEF, 0, 2, 1, 0, 0), 99);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/lsu_mem_master.md
# lsu_mem_master

Load/store initiator between the core's memory stage and the word-addressed data RAM black box. It accepts one byte, halfword or word access per handshake and checks natural alignment. Loads are extracted and sign/zero-extended from the aligned word; sub-word stores use a read-modify-write sequence. It presents a single-outstanding request/response handshake to the pipeline and drives the RAM's `valid`/`mem_wen`/`addr`/`wdata` side.

## Interface
- `ADDR_WIDTH`, 32, byte address width
- `DATA_WIDTH`, 32, word width; fixed at 32, other values unsupported
- `clock`  in  1  single clock; all state updates on rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `req_valid`  in  1  pipeline request present
- `req_ready`  out  1  block can accept a request
- `req_wen`  in  1  1 = store, 0 = load
- `req_size`  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- `req_unsigned`  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data, right-justified
- `resp_valid`  out  1  response present
- `resp_ready`  in  1  pipeline consumes response
- `resp_rdata`  out  32  extended load data; 0 for stores
- `resp_err`  out  1  misaligned or illegal-size access; no memory access was made
- `mem_valid`  out  1  RAM request strobe
- `mem_wen`  out  1  RAM write enable
- `mem_addr`  out  32  `{addr[31:2], 2'b00}`
- `mem_wdata`  out  32  full word to write
- `mem_rdata`  in  32  RAM read word; valid by the rising edge ending a `mem_valid` cycle

## Operation
- States: IDLE, RD, RMW_RD, WR, RESP.
- IDLE: `req_ready=1`. On `req_valid`, latch addr, size, wen, unsigned, wdata, then:
  - error if size==3, half with addr[0]=1, or word with addr[1:0]!=0 → RESP with `resp_err=1`
  - load → RD
  - word store → WR with `mem_wdata=req_wdata`
  - byte/half store → RMW_RD
- RD: `mem_valid=1`, `mem_wen=0`. Capture `mem_rdata`, select the lane given by addr[1:0], extend to 32 bits → RESP.
- RMW_RD: same strobe as RD. Capture the word and merge the store data:
  - byte: lane addr[1:0] = wdata[7:0]
  - half: bytes addr[1]*2 .. +1 = wdata[15:0]
  - other bytes keep the read value
  - → WR
- WR: `mem_valid=1`, `mem_wen=1`, `mem_wdata` = merged or full word → RESP.
- RESP: `resp_valid=1`; rdata/err held stable. On `resp_ready` → IDLE. No new request is accepted in the same cycle as a response handshake.
- `mem_valid` is low in IDLE and RESP. `mem_addr` and `mem_wdata` are 0 when `mem_valid=0`.
- Single outstanding access only; `req_*` may change freely after acceptance.

## Timing
- Reset (`reset_n=0` at an edge):
  - state → IDLE; latched registers cleared
  - while `reset_n` is low, all outputs = 0, including `req_ready` and `mem_valid`
  - reset mid-operation abandons the access. A WR cycle with `reset_n` low issues no write; a write already strobed before reset is not undone.
- Latency, with acceptance edge = cycle 0:
  - load: RD cycle 1, `resp_valid` from cycle 2
  - word store: WR cycle 1, response cycle 2
  - sub-word store: RMW_RD cycle 1, WR cycle 2, response cycle 3
  - error: response cycle 1, zero RAM strobes
- Back-to-back throughput: one access per 3 cycles (loads/word stores) or 4 cycles (sub-word stores) with `resp_ready` held high.
- `resp_valid` stays asserted with stable data until `resp_ready`; any stall length is allowed.

## Structure
- Package `lsu_pkg`:
  - size encodings `SZ_B`, `SZ_H`, `SZ_W`
  - state enum
  - `ADDR_WIDTH` / `DATA_WIDTH` constants
- Sub-module `lsu_align` (combinational):
  - inputs: word, addr[1:0], size, unsigned, store data
  - outputs: extended load value, merged store word, misalign flag
- The FSM and registers live in `lsu_mem_master`.

## Test plan
- Load byte signed, RAM word 0x80FF_7F01 at 0x100, addr 0x103 → `resp_rdata=0xFFFF_FF80` at cycle 2; same with `req_unsigned=1` → 0x0000_0080; exactly one `mem_valid` cycle, `mem_addr=0x100`.
- Store half 0xBEEF to 0x102 over word 0x1122_3344 → one read strobe then one write strobe with `mem_wdata=0xBEEF_3344`; response at cycle 3, `resp_rdata=0`.
- Word store 0xDEAD_BEEF to 0x200 → single write strobe cycle 1; a following word load from 0x200 returns 0xDEAD_BEEF.
- Misaligned: word at 0x102, half at 0x101, size=3 → `resp_err=1` at cycle 1, `mem_valid` never asserted.
- `resp_ready` held low 5 cycles → `resp_valid`/`resp_rdata` stable, `req_ready=0` throughout; IDLE follows the cycle after the handshake.
- Drop `reset_n` during the WR cycle of a byte store → no write strobe that cycle; all outputs 0; after release `req_ready=1` and the RAM word is unchanged.
